axi_arbitrate_wr: RTL and testbench

- Write-side counterpart of the DDR read arbiter: collects pixel data from four video input channels and writes it into per-channel ping-pong frame buffers in DDR over the AXI write channel.
- Each channel presents a first-word-fall-through (FWFT) line buffer holding pre-scaled quadrant pixels (RGB565) in the `clk` domain.
- The block round-robins between channels, issues fixed-length INCR bursts, and tracks each channel's address and its frame buffer (ping or pong).
- It exports each channel's completed frame buffer so the read side always fetches a finished frame.

---
 rtl/axi_vid_pkg.sv | 11 +
 rtl/rr_arbiter4.sv | 35 +++
 rtl/axi_arbitrate_wr.sv | 154 +++++++++++++++
 tb/tb_axi_arbitrate_wr.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi_vid_pkg.sv
// axi_vid_pkg: shared FSM encoding, AXI constants and frame sizing for the video write arbiter
package axi_vid_pkg;
   localparam int NUM_CH = 4;
   localparam logic [2:0] SIZE_32B = 3'b101;
   localparam logic [1:0] BURST_INCR = 2'b01;
   typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;
   // Beats in one quadrant frame: quarter-size image of 16-bit pixels packed into DQ_WIDTH*8-bit beats
   function automatic int frame_beats(int h, int v, int dq);
      return (h / 2) * (v / 2) * 16 / (dq * 8);
   endfunction
endpackage

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-way round-robin grant with a registered priority pointer
//   req       : per-channel request
//   upd       : load upd_ptr into the pointer (end of a served burst)
//   gnt       : first requesting index at or after the pointer, wrapping
//   gnt_valid : any request present
module rr_arbiter4
   import axi_vid_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic       upd,
   input  logic [1:0] upd_ptr,
   output logic [1:0] gnt,
   output logic       gnt_valid
);
   logic [1:0] ptr_q, ptr_d, idx;
   always_comb begin
      ptr_d     = upd ? upd_ptr : ptr_q;
      gnt       = '0;
      gnt_valid = 1'b0;
      idx       = '0;
      // Scan from the farthest offset down so the closest request to the pointer wins
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         idx = ptr_q + 2'(i);
         if (req[idx]) begin
            gnt       = idx;
            gnt_valid = 1'b1;
         end
      end
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
endmodule

// File: rtl/axi_arbitrate_wr.sv
// axi_arbitrate_wr: round-robin writer of four FWFT video line buffers into ping-pong DDR frame buffers
//   vsync/buf_rdy/buf_rd_data/buf_rd_en : per-channel frame sync, burst-ready flag, head word, pop strobe
//   axi_aw*/axi_w*/axi_b*                : AXI write address, data and response channels
//   rd_frame_sel                         : per-channel buffer holding the last completed frame
//   ovf_flag                             : sticky per-channel frame overflow
module axi_arbitrate_wr
   import axi_vid_pkg::*;
#(
   parameter int MEM_ROW_WIDTH     = 15,
   parameter int MEM_COLUMN_WIDTH  = 10,
   parameter int MEM_BANK_WIDTH    = 3,
   parameter int CTRL_ADDR_WIDTH   = MEM_ROW_WIDTH + MEM_BANK_WIDTH + MEM_COLUMN_WIDTH,
   parameter int DQ_WIDTH          = 32,
   parameter int H_WIDTH           = 1280,
   parameter int H_HEIGHT          = 720,
   parameter int BURST_LEN         = 16,
   parameter int FRAME_ADDR_OFFSET = 131072,
   parameter int CH_ADDR_OFFSET    = 262144
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [3:0]                   vsync,
   input  logic [3:0]                   buf_rdy,
   input  logic [4*DQ_WIDTH*8-1:0]      buf_rd_data,
   output logic [3:0]                   buf_rd_en,
   output logic                         axi_awvalid,
   input  logic                         axi_awready,
   output logic [CTRL_ADDR_WIDTH-1:0]   axi_awaddr,
   output logic [3:0]                   axi_awid,
   output logic [3:0]                   axi_awlen,
   output logic [2:0]                   axi_awsize,
   output logic [1:0]                   axi_awburst,
   output logic                         axi_wvalid,
   input  logic                         axi_wready,
   output logic [DQ_WIDTH*8-1:0]        axi_wdata,
   output logic [DQ_WIDTH-1:0]          axi_wstrb,
   output logic                         axi_wlast,
   input  logic                         axi_bvalid,
   output logic                         axi_bready,
   input  logic [3:0]                   axi_bid,
   output logic [3:0]                   rd_frame_sel,
   output logic [3:0]                   ovf_flag
);
   localparam int DW = DQ_WIDTH * 8;
   localparam int FRAME_BEATS = frame_beats(H_WIDTH, H_HEIGHT, DQ_WIDTH);
   state_t state_q, state_d;
   logic [1:0] gnt_q, gnt_d, gnt;
   logic [3:0] beat_q, beat_d;
   logic [CTRL_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
   logic [NUM_CH-1:0][15:0] cnt_q, cnt_d;
   logic [3:0] wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d, ovf_q, ovf_d, pend_q, pend_d, vs_q;
   logic [3:0] pend, apply;
   logic [15:0] g_cnt;
   logic gnt_valid, b_done, unused_bid;
   assign unused_bid = ^axi_bid;
   assign b_done = state_q == S_B && axi_bvalid;
   rr_arbiter4 u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (buf_rdy),
      .upd       (b_done),
      .upd_ptr   (gnt_q + 2'd1),
      .gnt       (gnt),
      .gnt_valid (gnt_valid)
   );
   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      beat_d   = beat_q;
      awaddr_d = awaddr_q;
      cnt_d    = cnt_q;
      wr_sel_d = wr_sel_q;
      rd_sel_d = rd_sel_q;
      ovf_d    = ovf_q;
      apply    = '0;
      g_cnt    = '0;
      pend     = pend_q | (vsync & ~vs_q);
      // A frame switch never lands inside a burst of that channel; it waits for the burst to retire
      for (int n = 0; n < NUM_CH; n++) begin
         apply[n] = pend[n] && (state_q == S_IDLE || gnt_q != 2'(n) || b_done);
         if (apply[n]) begin
            rd_sel_d[n] = wr_sel_q[n];
            wr_sel_d[n] = ~wr_sel_q[n];
            cnt_d[n]    = '0;
         end
      end
      pend_d = pend & ~apply;
      case (state_q)
         S_IDLE: if (gnt_valid) begin
            g_cnt = cnt_d[gnt];
            if (32'(g_cnt) + BURST_LEN > FRAME_BEATS) begin
               g_cnt      = '0;
               ovf_d[gnt] = 1'b1;
            end
            cnt_d[gnt] = g_cnt;
            awaddr_d   = CTRL_ADDR_WIDTH'(CH_ADDR_OFFSET * int'(gnt)
                         + FRAME_ADDR_OFFSET * int'(wr_sel_d[gnt]) + int'(g_cnt) * 8);
            gnt_d      = gnt;
            state_d    = S_AW;
         end
         S_AW: if (axi_awready) begin
            beat_d  = '0;
            state_d = S_W;
         end
         S_W: if (axi_wready) begin
            beat_d = beat_q + 4'd1;
            if (axi_wlast) begin
               cnt_d[gnt_q] = cnt_q[gnt_q] + 16'(BURST_LEN);
               state_d      = S_B;
            end
         end
         S_B: state_d = axi_bvalid ? S_IDLE : S_B;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q  <= S_IDLE;
         gnt_q    <= '0;
         beat_q   <= '0;
         awaddr_q <= '0;
         cnt_q    <= '0;
         wr_sel_q <= '0;
         rd_sel_q <= '1;
         ovf_q    <= '0;
         pend_q   <= '0;
         vs_q     <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         beat_q   <= beat_d;
         awaddr_q <= awaddr_d;
         cnt_q    <= cnt_d;
         wr_sel_q <= wr_sel_d;
         rd_sel_q <= rd_sel_d;
         ovf_q    <= ovf_d;
         pend_q   <= pend_d;
         vs_q     <= vsync;
      end
   assign axi_awvalid  = state_q == S_AW;
   assign axi_awaddr   = awaddr_q;
   assign axi_awid     = {2'b00, gnt_q};
   assign axi_awlen    = 4'(BURST_LEN - 1);
   assign axi_awsize   = SIZE_32B;
   assign axi_awburst  = BURST_INCR;
   assign axi_wvalid   = state_q == S_W;
   assign axi_wlast    = axi_wvalid && beat_q == 4'(BURST_LEN - 1);
   assign axi_wdata    = axi_wvalid ? buf_rd_data[gnt_q * DW +: DW] : '0;
   assign axi_wstrb    = '1;
   assign axi_bready   = 1'b1;
   // Pops track accepted beats exactly, so the FWFT head is always the next beat to send
   assign buf_rd_en    = (axi_wvalid && axi_wready) ? 4'b0001 << gnt_q : 4'b0000;
   assign rd_frame_sel = rd_sel_q;
   assign ovf_flag     = ovf_q;
endmodule

// File: tb/tb_axi_arbitrate_wr.sv
// tb_axi_arbitrate_wr: burst table plus vsync, overflow and reset sequences against an AXI slave model
module tb_axi_arbitrate_wr;
   typedef struct packed {
      logic [3:0]  id;
      logic [27:0] addr;
   } exp_t;
   typedef struct packed {
      logic [3:0]  rdy;
      int          aw_stall;
      bit          w_tog;
      logic [3:0]  id;
      logic [27:0] addr;
   } vec_t;
   logic clk, rst;
   logic [3:0] vsync, buf_rdy, buf_rd_en, axi_awid, axi_awlen, axi_bid, rd_frame_sel, ovf_flag;
   logic [1023:0] buf_rd_data;
   logic axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_wlast, axi_bvalid, axi_bready;
   logic [27:0] axi_awaddr;
   logic [2:0] axi_awsize;
   logic [1:0] axi_awburst;
   logic [255:0] axi_wdata;
   logic [31:0] axi_wstrb;
   int checks = 0, errors = 0;
   int pop_cnt [4] = '{0, 0, 0, 0};
   int exp_pop [4] = '{0, 0, 0, 0};
   logic [3:0] pop_pend = '0;
   logic [3:0] pat = 4'b1001;
   exp_t exp_q [$];
   vec_t tbl [10];
   int aw_stall_cfg = 0, aw_wait = 0, w_idx = 0, beats = 0, rd_pulses = 0, cur_ch = 0, bursts_done = 0;
   bit w_tog = 0, b_pend = 0;

   axi_arbitrate_wr dut (
      .clk(clk), .rst(rst), .vsync(vsync), .buf_rdy(buf_rdy), .buf_rd_data(buf_rd_data),
      .buf_rd_en(buf_rd_en), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
      .axi_awaddr(axi_awaddr), .axi_awid(axi_awid), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
      .axi_awburst(axi_awburst), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
      .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast), .axi_bvalid(axi_bvalid),
      .axi_bready(axi_bready), .axi_bid(axi_bid), .rd_frame_sel(rd_frame_sel), .ovf_flag(ovf_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [255:0] make_word(int ch, int idx);
      return {8{{8'(ch), 24'(idx)}}};
   endfunction

   always_comb
      for (int n = 0; n < 4; n++) buf_rd_data[n*256 +: 256] = make_word(n, pop_cnt[n]);

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Slave model: drives readies/response at negedge, then predicts and checks the handshakes of the next edge
   always @(negedge clk) begin
      for (int n = 0; n < 4; n++) if (pop_pend[n]) pop_cnt[n]++;
      pop_pend = '0;
      if (rst) begin
         axi_awready = 1'b0;
         axi_wready  = 1'b0;
         axi_bvalid  = 1'b0;
         b_pend = 0;
         aw_wait = 0;
         beats = 0;
         rd_pulses = 0;
      end else begin
         axi_bvalid  = b_pend;
         axi_awready = !(axi_awvalid && aw_wait < aw_stall_cfg);
         axi_wready  = w_tog ? pat[w_idx % 4] : 1'b1;
         w_idx++;
         #1;
         if (axi_awvalid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL aw_unexpected: got id %0d addr %0h, required no burst", axi_awid, axi_awaddr);
            end else begin
               chk("aw_id", 256'(axi_awid), 256'(exp_q[0].id));
               chk("aw_addr", 256'(axi_awaddr), 256'(exp_q[0].addr));
               if (axi_awready) begin
                  chk("aw_len", 256'(axi_awlen), 256'(15));
                  chk("aw_size_burst", 256'({axi_awsize, axi_awburst}), 256'({3'b101, 2'b01}));
                  chk("w_strb", 256'(axi_wstrb), 256'(32'hffff_ffff));
                  cur_ch = int'(exp_q[0].id);
                  void'(exp_q.pop_front());
                  aw_wait = 0;
                  beats = 0;
                  rd_pulses = 0;
               end else aw_wait++;
            end
         end
         chk("rd_en", 256'(buf_rd_en), 256'((axi_wvalid && axi_wready) ? 4'b0001 << cur_ch : 4'b0000));
         if (buf_rd_en != 0) rd_pulses++;
         if (axi_wvalid) begin
            chk("w_data", axi_wdata, make_word(cur_ch, exp_pop[cur_ch]));
            chk("w_last", 256'(axi_wlast), 256'(beats == 15));
            if (axi_wready) begin
               exp_pop[cur_ch]++;
               beats++;
               if (axi_wlast) begin
                  chk("pops_per_burst", 256'(rd_pulses), 256'(16));
                  b_pend = 1;
               end
            end
         end
         if (axi_bvalid && axi_bready) begin
            b_pend = 0;
            bursts_done++;
         end
         pop_pend = buf_rd_en;
      end
   end

   task automatic wait_done(input int start);
      int t;
      t = 0;
      while (bursts_done == start && t < 200) begin
         @(negedge clk);
         #2;
         t++;
      end
      checks++;
      if (bursts_done == start) begin
         errors++;
         $display("FAIL burst_timeout: got %0d bursts, required %0d", bursts_done, start + 1);
      end
      buf_rdy = '0;
   endtask

   task automatic run_burst(input logic [3:0] rdy, input logic [3:0] id, input logic [27:0] addr);
      int start;
      start = bursts_done;
      exp_q.push_back('{id, addr});
      buf_rdy = rdy;
      wait_done(start);
   endtask

   task automatic wait_beat(input int n);
      int t;
      t = 0;
      while (!(axi_wvalid && beats == n) && t < 200) begin
         @(negedge clk);
         #2;
         t++;
      end
      chk("beat_reached", 256'(beats), 256'(n));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, %0d bursts done", bursts_done);
      $fatal(1, "watchdog");
   end

   initial begin
      int start;
      tbl[0] = '{4'b1111, 0, 1'b0, 4'd0, 28'd0};
      tbl[1] = '{4'b1111, 0, 1'b0, 4'd1, 28'd262144};
      tbl[2] = '{4'b1111, 0, 1'b0, 4'd2, 28'd524288};
      tbl[3] = '{4'b1111, 0, 1'b0, 4'd3, 28'd786432};
      tbl[4] = '{4'b1111, 0, 1'b0, 4'd0, 28'd128};
      tbl[5] = '{4'b0001, 0, 1'b0, 4'd0, 28'd256};
      tbl[6] = '{4'b0001, 0, 1'b0, 4'd0, 28'd384};
      tbl[7] = '{4'b0100, 3, 1'b1, 4'd2, 28'd524416};
      tbl[8] = '{4'b1010, 3, 1'b1, 4'd3, 28'd786560};
      tbl[9] = '{4'b0010, 0, 1'b0, 4'd1, 28'd262272};
      rst = 1'b1;
      vsync = '0;
      buf_rdy = '0;
      axi_bid = '0;
      repeat (3) @(negedge clk);
      #2;
      chk("rst_valids", 256'({axi_awvalid, axi_wvalid, axi_wlast}), 256'(0));
      chk("rst_rd_en", 256'(buf_rd_en), 256'(0));
      chk("rst_addr_id", 256'({axi_awaddr, axi_awid}), 256'(0));
      chk("rst_bready", 256'(axi_bready), 256'(1));
      chk("rst_frame_sel", 256'(rd_frame_sel), 256'(4'b1111));
      chk("rst_ovf", 256'(ovf_flag), 256'(0));
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         aw_stall_cfg = tbl[i].aw_stall;
         w_tog = tbl[i].w_tog;
         run_burst(tbl[i].rdy, tbl[i].id, tbl[i].addr);
      end
      aw_stall_cfg = 0;
      w_tog = 0;
      start = bursts_done;
      exp_q.push_back('{4'd0, 28'd512});
      buf_rdy = 4'b0001;
      wait_beat(5);
      vsync = 4'b0001;
      wait_done(start);
      run_burst(4'b0001, 4'd0, 28'd131072);
      chk("frame_sel_after_vs0", 256'(rd_frame_sel), 256'(4'b1110));
      vsync = 4'b0000;
      repeat (2) @(negedge clk);
      vsync = 4'b0010;
      repeat (2) @(negedge clk);
      vsync = 4'b0000;
      repeat (2) @(negedge clk);
      #2;
      chk("frame_sel_after_vs1", 256'(rd_frame_sel), 256'(4'b1100));
      for (int k = 0; k <= 900; k++) begin
         if (k == 900) chk("ovf_before_wrap", 256'(ovf_flag), 256'(0));
         run_burst(4'b0010, 4'd1, 28'(393216 + (k == 900 ? 0 : k * 128)));
      end
      chk("ovf_after_wrap", 256'(ovf_flag), 256'(4'b0010));
      exp_q.push_back('{4'd0, 28'd131200});
      buf_rdy = 4'b0001;
      wait_beat(3);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("async_rst_valids", 256'({axi_awvalid, axi_wvalid, axi_wlast}), 256'(0));
      chk("async_rst_rd_en", 256'(buf_rd_en), 256'(0));
      chk("async_rst_frame_sel", 256'(rd_frame_sel), 256'(4'b1111));
      chk("async_rst_ovf", 256'(ovf_flag), 256'(0));
      exp_q.delete();
      buf_rdy = '0;
      repeat (2) @(negedge clk);
      #2;
      rst = 1'b0;
      run_burst(4'b1111, 4'd0, 28'd0);
      run_burst(4'b1111, 4'd1, 28'd262144);
      chk("queue_drained", 256'(exp_q.size()), 256'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
